// File: rtl/specialkeys_scan_pkg.sv
// Shared scancode constants, osd_command bit indices and the prefix FSM state type.
// Shared by specialkeys_scan, the OSD menu and the special-keys handler.
package specialkeys_scan_pkg;

  // Prefix bytes
  localparam logic [7:0] ScPrefixExt   = 8'hE0;
  localparam logic [7:0] ScPrefixBreak = 8'hF0;
  localparam logic [7:0] ScPrefixPause = 8'hE1;

  // Base-table codes
  localparam logic [7:0] ScF12        = 8'h07;
  localparam logic [7:0] ScF11        = 8'h78;
  localparam logic [7:0] ScScrollLock = 8'h7E;
  localparam logic [7:0] ScEnter      = 8'h5A;

  // Extended-table codes (E0-prefixed); 5A doubles as keypad Enter
  localparam logic [7:0] ScUp    = 8'h75;
  localparam logic [7:0] ScDown  = 8'h72;
  localparam logic [7:0] ScLeft  = 8'h6B;
  localparam logic [7:0] ScRight = 8'h74;

  // Ctrl/Alt are in both tables (left/right), Del is extended only
  localparam logic [7:0] ScCtrl = 8'h14;
  localparam logic [7:0] ScAlt  = 8'h11;
  localparam logic [7:0] ScDel  = 8'h71;

  // Bytes following E1 in the Pause sequence
  localparam logic [2:0] PauseSkip = 3'd7;

  // osd_command bit indices
  localparam logic [2:0] OsdEnterBit  = 3'd7;
  localparam logic [2:0] OsdRightBit  = 3'd6;
  localparam logic [2:0] OsdLeftBit   = 3'd5;
  localparam logic [2:0] OsdDownBit   = 3'd4;
  localparam logic [2:0] OsdUpBit     = 3'd3;
  localparam logic [2:0] OsdF11Bit    = 3'd2;
  localparam logic [2:0] OsdF12Bit    = 3'd1;
  localparam logic [2:0] OsdScrollBit = 3'd0;

  typedef enum logic [2:0] {StIdle, StE0, StF0, StE0F0, StPause} scan_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_sel_t;

  // Map a decoded code to its osd_command bit; keypad digits (non-E0 arrows) miss
  function automatic key_sel_t osd_key_lookup(input logic ext, input logic [7:0] code);
    key_sel_t sel;
    sel.hit = 1'b1;
    sel.idx = 3'd0;
    if (!ext) begin
      case (code)
        ScF12:        sel.idx = OsdF12Bit;
        ScF11:        sel.idx = OsdF11Bit;
        ScScrollLock: sel.idx = OsdScrollBit;
        ScEnter:      sel.idx = OsdEnterBit;
        default:      sel.hit = 1'b0;
      endcase
    end else begin
      case (code)
        ScUp:    sel.idx = OsdUpBit;
        ScDown:  sel.idx = OsdDownBit;
        ScLeft:  sel.idx = OsdLeftBit;
        ScRight: sel.idx = OsdRightBit;
        ScEnter: sel.idx = OsdEnterBit;
        default: sel.hit = 1'b0;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/specialkeys_scan_prefix_fsm.sv
// Tracks E0/F0/E1 prefixes, swallows the Pause sequence and abandons a stale
// prefix after TIMEOUT_CYCLES idle cycles. Qualifies each byte combinationally
// so the key registers in the top level update on the byte's own clock edge.
module specialkeys_scan_prefix_fsm
  import specialkeys_scan_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 3000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] scancode,
  input  logic       scancode_rdy,
  output logic       is_make,
  output logic       is_ext,
  output logic       code_valid,
  output logic       err
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  scan_state_e     state_q;
  logic [2:0]      skip_q;
  logic [CntW-1:0] tmo_q;
  logic            timeout;

  assign timeout = (state_q != StIdle) && (tmo_q == CntW'(TIMEOUT_CYCLES - 1));

  // Classify the current byte against the current prefix state
  always_comb begin
    is_make    = 1'b0;
    is_ext     = 1'b0;
    code_valid = 1'b0;
    err        = 1'b0;
    if (scancode_rdy) begin
      unique case (state_q)
        StIdle: begin
          if (scancode != ScPrefixExt && scancode != ScPrefixBreak &&
              scancode != ScPrefixPause) begin
            code_valid = 1'b1;
            is_make    = 1'b1;
          end
        end
        StE0: begin
          if (scancode == ScPrefixExt) begin
            err = 1'b1;
          end else if (scancode != ScPrefixBreak) begin
            code_valid = 1'b1;
            is_make    = 1'b1;
            is_ext     = 1'b1;
          end
        end
        StF0: code_valid = 1'b1;
        StE0F0: begin
          code_valid = 1'b1;
          is_ext     = 1'b1;
        end
        default: ;
      endcase
    end else begin
      // A byte arriving on the expiry cycle wins, so only flag when idle
      err = timeout;
    end
  end

  // Prefix state, Pause skip counter and idle timeout counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      skip_q  <= 3'd0;
      tmo_q   <= '0;
    end else if (scancode_rdy) begin
      tmo_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (scancode == ScPrefixExt) begin
            state_q <= StE0;
          end else if (scancode == ScPrefixBreak) begin
            state_q <= StF0;
          end else if (scancode == ScPrefixPause) begin
            state_q <= StPause;
            skip_q  <= PauseSkip;
          end
        end
        StE0: begin
          if (scancode == ScPrefixBreak) begin
            state_q <= StE0F0;
          end else if (scancode != ScPrefixExt) begin
            state_q <= StIdle;
          end
        end
        StPause: begin
          skip_q <= skip_q - 3'd1;
          if (skip_q <= 3'd1) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (timeout) begin
        state_q <= StIdle;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/specialkeys_scan.sv
// PS/2 set-2 decoder for the special/host keys: holds F12, ScrollLock, F11,
// arrows and Enter as level bits. Matrix keys are ignored here.
// Optional build macro SPECIALKEYS_CTRLALTDEL_EN adds Ctrl+Alt+Del to key_blksbr.
module specialkeys_scan
  import specialkeys_scan_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 3000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] scancode,
  input  logic       scancode_rdy,
  output logic       key_blksbr,
  output logic       key_osd,
  output logic [7:0] osd_command,
  output logic       prefix_err
);

  logic     is_make;
  logic     is_ext;
  logic     code_valid;
  logic     err;
  key_sel_t sel;
  logic [7:0] held_q;
  logic       prefix_err_q;

  specialkeys_scan_prefix_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_prefix_fsm (
    .clk          (clk),
    .reset_n      (reset_n),
    .scancode     (scancode),
    .scancode_rdy (scancode_rdy),
    .is_make      (is_make),
    .is_ext       (is_ext),
    .code_valid   (code_valid),
    .err          (err)
  );

  assign sel = osd_key_lookup(is_ext, scancode);

  // OSD key held bits and the registered error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_q       <= 8'h00;
      prefix_err_q <= 1'b0;
    end else begin
      prefix_err_q <= err;
      if (code_valid && sel.hit) held_q[sel.idx] <= is_make;
    end
  end

`ifdef SPECIALKEYS_CTRLALTDEL_EN
  // Bits: 0 LCtrl, 1 RCtrl, 2 LAlt, 3 RAlt, 4 Del
  function automatic key_sel_t cad_lookup(input logic ext, input logic [7:0] code);
    key_sel_t s;
    s.hit = 1'b1;
    s.idx = 3'd0;
    case ({ext, code})
      {1'b0, ScCtrl}: s.idx = 3'd0;
      {1'b1, ScCtrl}: s.idx = 3'd1;
      {1'b0, ScAlt}:  s.idx = 3'd2;
      {1'b1, ScAlt}:  s.idx = 3'd3;
      {1'b1, ScDel}:  s.idx = 3'd4;
      default:        s.hit = 1'b0;
    endcase
    return s;
  endfunction

  key_sel_t   cad_sel;
  logic [4:0] cad_q;

  assign cad_sel = cad_lookup(is_ext, scancode);

  // Ctrl/Alt/Del held bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cad_q <= 5'b0;
    end else if (code_valid && cad_sel.hit) begin
      cad_q[cad_sel.idx] <= is_make;
    end
  end

  assign key_blksbr = held_q[OsdF12Bit] |
                      ((cad_q[0] | cad_q[1]) & (cad_q[2] | cad_q[3]) & cad_q[4]);
`else
  assign key_blksbr = held_q[OsdF12Bit];
`endif

  assign key_osd     = held_q[OsdScrollBit];
  assign osd_command = held_q;
  assign prefix_err  = prefix_err_q;

endmodule

// File: tb/tb_specialkeys_scan.sv
module tb_specialkeys_scan;

  localparam int unsigned T = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] scancode;
  logic       scancode_rdy;
  logic       key_blksbr;
  logic       key_osd;
  logic [7:0] osd_command;
  logic       prefix_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] code;
    logic [7:0] exp_osd;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  specialkeys_scan #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .scancode     (scancode),
    .scancode_rdy (scancode_rdy),
    .key_blksbr   (key_blksbr),
    .key_osd      (key_osd),
    .osd_command  (osd_command),
    .prefix_err   (prefix_err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input logic [7:0] code, input logic [7:0] osd, input logic e);
    vec_t r;
    r.code    = code;
    r.exp_osd = osd;
    r.exp_err = e;
    vecs.push_back(r);
  endtask

  // One-cycle strobe; returns 1 ns after the consuming edge
  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    scancode     = b;
    scancode_rdy = 1'b1;
    @(posedge clk);
    #1;
    scancode_rdy = 1'b0;
  endtask

  task automatic check_outs(input string name, input logic [7:0] osd, input logic blk,
                            input logic kosd, input logic e);
    check({name, " osd_command"}, osd_command, osd);
    check({name, " key_blksbr"}, key_blksbr, blk);
    check({name, " key_osd"}, key_osd, kosd);
    check({name, " prefix_err"}, prefix_err, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int first;

    reset_n      = 1'b0;
    scancode     = 8'h00;
    scancode_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // F12 make/break
    v(8'h07, 8'h02, 0); v(8'hF0, 8'h02, 0); v(8'h07, 8'h00, 0);
    // Up make/break, bare keypad 8 ignored
    v(8'hE0, 8'h00, 0); v(8'h75, 8'h08, 0); v(8'hE0, 8'h08, 0); v(8'hF0, 8'h08, 0);
    v(8'h75, 8'h00, 0); v(8'h75, 8'h00, 0); v(8'hF0, 8'h00, 0); v(8'h75, 8'h00, 0);
    // Pause swallowed, then ScrollLock
    v(8'hE1, 8'h00, 0); v(8'h14, 8'h00, 0); v(8'h77, 8'h00, 0); v(8'hE1, 8'h00, 0);
    v(8'hF0, 8'h00, 0); v(8'h14, 8'h00, 0); v(8'hF0, 8'h00, 0); v(8'h77, 8'h00, 0);
    v(8'h7E, 8'h01, 0);
    // F11, Enter (base and keypad), typematic repeat
    v(8'h78, 8'h05, 0); v(8'h5A, 8'h85, 0); v(8'hE0, 8'h85, 0); v(8'h5A, 8'h85, 0);
    v(8'hE0, 8'h85, 0); v(8'hF0, 8'h85, 0); v(8'h5A, 8'h05, 0); v(8'h78, 8'h05, 0);
    v(8'hF0, 8'h05, 0); v(8'h78, 8'h01, 0); v(8'hF0, 8'h01, 0); v(8'h7E, 8'h00, 0);
    // E0 E0 flags error and stays in E0
    v(8'hE0, 8'h00, 0); v(8'hE0, 8'h00, 1); v(8'h74, 8'h40, 0);
    v(8'hE0, 8'h40, 0); v(8'hF0, 8'h40, 0); v(8'h74, 8'h00, 0);
    // Left/Down overlapping, unlisted code
    v(8'hE0, 8'h00, 0); v(8'h6B, 8'h20, 0); v(8'hE0, 8'h20, 0); v(8'h72, 8'h30, 0);
    v(8'hE0, 8'h30, 0); v(8'hF0, 8'h30, 0); v(8'h6B, 8'h10, 0); v(8'hE0, 8'h10, 0);
    v(8'hF0, 8'h10, 0); v(8'h72, 8'h00, 0); v(8'h1C, 8'h00, 0);

    foreach (vecs[i]) begin
      send(vecs[i].code);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_osd, vecs[i].exp_osd[1],
                 vecs[i].exp_osd[0], vecs[i].exp_err);
    end

    // Timeout after a lone E0: one pulse, exactly T cycles later
    send(8'hE0);
    pulses = 0;
    first  = -1;
    for (int k = 1; k <= 2 * T; k++) begin
      @(posedge clk);
      #1;
      if (prefix_err) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check("timeout pulse count", pulses, 1);
    check("timeout pulse cycle", first, T);
    send(8'h75);
    check("after timeout keypad 8", osd_command, 8'h00);
    send(8'h5A);
    check("after timeout enter", osd_command, 8'h80);
    send(8'hF0);
    send(8'h5A);
    check("enter release", osd_command, 8'h00);

    // Byte arriving on the expiry cycle wins
    send(8'hE0);
    repeat (T - 1) @(posedge clk);
    #1;
    scancode     = 8'h75;
    scancode_rdy = 1'b1;
    @(posedge clk);
    #1;
    scancode_rdy = 1'b0;
    check("collision up", osd_command, 8'h08);
    pulses = 0;
    for (int k = 0; k < 2 * T; k++) begin
      @(posedge clk);
      #1;
      if (prefix_err) pulses++;
    end
    check("collision no err", pulses, 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("collision up release", osd_command, 8'h00);

    // Back-to-back strobes
    @(posedge clk);
    #1;
    scancode_rdy = 1'b1;
    scancode = 8'h07; @(posedge clk); #1;
    scancode = 8'h7E; @(posedge clk); #1;
    scancode_rdy = 1'b0;
    check("b2b make", osd_command, 8'h03);
    scancode_rdy = 1'b1;
    scancode = 8'hF0; @(posedge clk); #1;
    scancode = 8'h07; @(posedge clk); #1;
    scancode = 8'hF0; @(posedge clk); #1;
    scancode = 8'h7E; @(posedge clk); #1;
    scancode_rdy = 1'b0;
    check("b2b break", osd_command, 8'h00);

    // Reset mid-sequence with F12 held
    send(8'h07);
    check("pre-reset blk", key_blksbr, 1);
    send(8'hF0);
    #2;
    reset_n = 1'b0;
    #2;
    check_outs("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send(8'h07);
    check("post-reset make blk", key_blksbr, 1);
    check("post-reset make osd", osd_command, 8'h02);
    send(8'hF0);
    send(8'h07);
    check("post-reset break", osd_command, 8'h00);

    // Ctrl+Alt+Del
    send(8'h14);
    send(8'h11);
    send(8'hE0);
    send(8'h71);
`ifdef SPECIALKEYS_CTRLALTDEL_EN
    check("cad blk", key_blksbr, 1);
`else
    check("cad blk", key_blksbr, 0);
`endif
    check("cad osd", osd_command, 8'h00);
    send(8'hF0);
    send(8'h11);
    check("cad alt release", key_blksbr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/specialkeys_scan.md
# specialkeys_scan

PS/2 set-2 scancode decoder for the special/host keys. It sits between the PS/2 byte receiver and the special-keys handler. It consumes raw scancode bytes and tracks the E0/F0/E1 prefixes. From them it produces level-held key states: BLK+SBR, OSD toggle key, and an 8-bit OSD command vector. Ordinary Vector-06C matrix keys are ignored here; the matrix mapper sees the same byte stream in parallel.

## Interface
- TIMEOUT_CYCLES, 24'd3000000, idle cycles after a prefix byte before the prefix state is abandoned (≈100 ms at 30 MHz)
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- scancode  in  8  received byte; valid only when scancode_rdy=1
- scancode_rdy  in  1  one-cycle strobe per received byte
- key_blksbr  out  1  F12 held (level)
- key_osd  out  1  ScrollLock held (level)
- osd_command  out  8  held keys {Enter,Right,Left,Down,Up,F11,F12,ScrollLock}, bit7..bit0
- prefix_err  out  1  one-cycle pulse when a prefix times out or an unexpected byte arrives

## Operation
- Byte FSM states: IDLE, E0, F0, E0F0, PAUSE.
- IDLE:
  - E0 -> E0; F0 -> F0; E1 -> PAUSE (skip counter=7).
  - Any other byte is a make code, base table; return to IDLE.
- E0:
  - F0 -> E0F0; E0 -> prefix_err, stay in E0.
  - Other byte is a make code, extended table -> IDLE.
- F0: byte is a break code, base table -> IDLE.
- E0F0: byte is a break code, extended table -> IDLE.
- PAUSE: swallow bytes until the skip counter reaches 0 -> IDLE; no key effect.
- Base table: 07=F12, 78=F11, 7E=ScrollLock, 5A=Enter.
- Extended table: 75=Up, 72=Down, 6B=Left, 74=Right, 5A=Enter (keypad).
  - Non-E0 75/72/6B/74 are keypad digits and do not set arrow bits.
- Make sets the key's held bit; break clears it. Unlisted codes are ignored silently.
- Typematic repeat (repeated make) leaves the held bit at 1; no pulses are generated.
- key_blksbr = held F12; key_osd = held ScrollLock. Both are duplicated into osd_command bits 1 and 0.
- Timeout:
  - A counter runs in E0, F0, E0F0 and PAUSE; it is cleared on every scancode_rdy.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE with a prefix_err pulse. Held bits are unchanged.
- Reset mid-sequence: FSM -> IDLE, all held bits 0, counter 0.

## Timing
- All outputs are registered. A held bit changes on the first clk edge after the scancode_rdy cycle of the final byte of a sequence, i.e. 1-cycle latency.
- Back-to-back scancode_rdy on consecutive cycles is supported; every byte is consumed.
- prefix_err is high for exactly one cycle.
- Reset values: key_blksbr=0, key_osd=0, osd_command=8'h00, prefix_err=0.
- A timeout expiring in the same cycle as scancode_rdy: the byte wins and the counter clears; no error is flagged.

## Configuration
- SPECIALKEYS_CTRLALTDEL_EN:
  - Defined: LCtrl(14)/RCtrl(E0 14), LAlt(11)/RAlt(E0 11) and Del(E0 71) are tracked as held bits. key_blksbr = F12 | (Ctrl & Alt & Del).
  - Undefined: these codes are ignored and key_blksbr = F12 only.
- osd_command is identical in both builds.

## Structure
- Shared package/include holds the scancode constants (prefixes E0/F0/E1, every code listed above) and the osd_command bit indices. The OSD menu and the special-keys handler reuse them.
- One sub-module: scan_prefix_fsm. It owns the state register, skip counter and timeout counter. It outputs {is_make, is_ext, code_valid, err}. The top level holds the key table and the held-bit registers.

## Test plan
- Bytes 07, then F0 07 -> key_blksbr=1 one cycle after the 07 strobe; returns to 0 one cycle after the final 07; osd_command[1] mirrors it.
- E0 75, E0 F0 75 -> osd_command=8'h08, then 8'h00. Bare 75 -> osd_command stays 8'h00.
- E1 14 77 E1 F0 14 F0 77, then 7E -> Pause is fully swallowed; only key_osd=1 afterwards.
- E0, then no byte for TIMEOUT_CYCLES -> one prefix_err pulse, FSM in IDLE. A following 5A sets osd_command[7].
- Assert reset_n=0 after F0, mid-sequence, with F12 held -> all outputs 0. After release, byte 07 is treated as a make code.
- With SPECIALKEYS_CTRLALTDEL_EN: 14, 11, E0 71 -> key_blksbr=1. F0 11 -> key_blksbr=0.
